// File: rtl/enc8b10b_pkg.sv
// Shared constants, types and helpers for the 8b/10b transmit scheduler.
package enc8b10b_pkg;

    localparam logic [7:0]  K28_5  = 8'hBC;
    localparam logic        RD_NEG = 1'b0;
    localparam logic        RD_POS = 1'b1;
    localparam int unsigned SYM_W  = 9;

    typedef enum logic {SYNC, DATA} state_t;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym_t;

    // Only the twelve defined 8b/10b control characters are legal K bytes.
    function automatic logic is_valid_k(input logic [7:0] b);
        case (b)
            8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
            8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ones10(input logic [9:0] code);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + 4'(code[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/enc_sym_fifo.sv
// Small circular FIFO of {k, data} symbols feeding the transmit scheduler.
module enc_sym_fifo
    import enc8b10b_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_pop,
    input  sym_t i_wdata,
    output logic o_full_c,
    output logic o_empty_c,
    output sym_t o_head_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    sym_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];

endmodule

// File: rtl/enc_tx_sched.sv
// 8b/10b transmit sequencer: sync burst, comma insertion, K checking,
// running-disparity ownership and registered code output.
module enc_tx_sched
    import enc8b10b_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SYNC_LEN     = 16,
    parameter int unsigned ALIGN_PERIOD = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_k,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       enc_rd,
    input  logic [9:0] enc_code,
    output logic       out_valid,
    output logic [9:0] out_code,
    output logic       rd_state,
    output logic       sync_done,
    output logic       k_err,
    output logic       disp_err
);

    localparam int unsigned SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int unsigned AW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_sync_cnt;
    logic [AW-1:0] r_align_cnt;
    logic          r_rd;
    logic          r_sync_done;
    logic          r_out_valid;
    logic [9:0]    r_out_code;
    logic          r_k_err;
    logic          r_disp_err;

    logic          w_full;
    logic          w_empty;
    sym_t          w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_sync_last;
    logic          w_force_align;
    logic          w_k_sub;
    logic          w_comma;
    logic [3:0]    w_ones;
    logic          w_rd_nxt;
    logic          w_disp_bad;

    assign w_push = in_valid && !w_full;

    enc_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wdata   ({in_k, in_data}),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_head_c  (w_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= SYNC;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sync_last = sym_en && (r_state == SYNC) && (r_sync_cnt == SW'(SYNC_LEN - 1));
        if (w_sync_last) w_state_nxt = DATA;
    end

    // Symbol selection: comma unless DATA with a waiting entry and no forced alignment.
    always_comb begin
        enc_data      = K28_5;
        enc_k         = 1'b1;
        w_pop         = 1'b0;
        w_k_sub       = 1'b0;
        w_force_align = 1'b0;
        if (r_state == DATA) begin
            w_force_align = (ALIGN_PERIOD != 0) && (r_align_cnt == AW'(ALIGN_PERIOD - 1));
            if (!w_force_align && !w_empty) begin
                w_pop = sym_en;
                if (w_head.k && !is_valid_k(w_head.data)) w_k_sub = 1'b1;
                else {enc_k, enc_data} = w_head;
            end
        end
    end

    assign w_comma = enc_k && (enc_data == K28_5);
    assign w_ones  = ones10(enc_code);

    // Only balanced codes or ones that flip RD in the legal direction are accepted.
    always_comb begin
        w_rd_nxt   = r_rd;
        w_disp_bad = 1'b0;
        if (w_ones == 4'd5) begin
            w_rd_nxt = r_rd;
        end else if ((w_ones == 4'd6) && (r_rd == RD_NEG)) begin
            w_rd_nxt = RD_POS;
        end else if ((w_ones == 4'd4) && (r_rd == RD_POS)) begin
            w_rd_nxt = RD_NEG;
        end else begin
            w_disp_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_cnt  <= '0;
            r_align_cnt <= '0;
            r_rd        <= RD_NEG;
            r_sync_done <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_k_err     <= 1'b0;
            r_disp_err  <= 1'b0;
        end else begin
            r_out_valid <= sym_en;
            r_k_err     <= sym_en && w_k_sub;
            r_disp_err  <= sym_en && w_disp_bad;
            if (sym_en) begin
                r_out_code <= enc_code;
                r_rd       <= w_rd_nxt;
                if (r_state == SYNC) r_sync_cnt <= r_sync_cnt + SW'(1);
                if (w_sync_last)     r_sync_done <= 1'b1;
                if (w_comma || (ALIGN_PERIOD == 0)) r_align_cnt <= '0;
                else                                r_align_cnt <= r_align_cnt + AW'(1);
            end
        end
    end

    assign in_ready  = !w_full;
    assign enc_rd    = r_rd;
    assign rd_state  = r_rd;
    assign sync_done = r_sync_done;
    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign k_err     = r_k_err;
    assign disp_err  = r_disp_err;

endmodule

// File: tb/tb_enc_tx_sched.sv
// Directed bench for enc_tx_sched with a queue-based reference model and a stub encoder.
module tb_enc_tx_sched;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned SYNC_LEN     = 4;
    localparam int unsigned ALIGN_PERIOD = 8;

    logic       clk;
    logic       reset;
    logic       sym_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_k;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       enc_rd;
    logic [9:0] enc_code;
    logic       out_valid;
    logic [9:0] out_code;
    logic       rd_state;
    logic       sync_done;
    logic       k_err;
    logic       disp_err;

    logic       ovr_en;
    logic [9:0] ovr_code;

    int n_chk;
    int n_err;
    int kerr_cnt;

    logic [8:0] mq[$];
    logic [8:0] sent[$];
    int         m_sync;
    int         m_align;
    logic       m_rd;
    logic       e_valid;
    logic       e_kerr;
    logic       e_derr;
    logic [9:0] e_code;

    logic [7:0] valid_k_list [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                      8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    enc_tx_sched #(
        .DEPTH        (DEPTH),
        .SYNC_LEN     (SYNC_LEN),
        .ALIGN_PERIOD (ALIGN_PERIOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_en    (sym_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k      (in_k),
        .enc_data  (enc_data),
        .enc_k     (enc_k),
        .enc_rd    (enc_rd),
        .enc_code  (enc_code),
        .out_valid (out_valid),
        .out_code  (out_code),
        .rd_state  (rd_state),
        .sync_done (sync_done),
        .k_err     (k_err),
        .disp_err  (disp_err)
    );

    // Stub encoder: real K28.5 codes (RD-dependent), every other byte gets a balanced word.
    function automatic logic [9:0] tb_enc(input logic [7:0] d, input logic k, input logic rd);
        if (k && d == 8'hBC) return rd ? 10'b1100000101 : 10'b0011111010;
        return {d[4:0], ~d[4:0]};
    endfunction

    function automatic bit k_ok(input logic [7:0] b);
        foreach (valid_k_list[i]) if (valid_k_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    assign enc_code = ovr_en ? ovr_code : tb_enc(enc_data, enc_k, enc_rd);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_sent(input string name, input int idx, input logic [8:0] exp);
        if (idx < sent.size()) chk(name, 32'(sent[idx]), 32'(exp));
        else                   chk(name, 32'hDEAD_0000, 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: advanced once per cycle at the falling edge.
    always @(negedge clk) begin : model_p
        logic [8:0] sym;
        logic [8:0] head;
        logic       do_pop;
        logic       sub;
        logic       do_push;
        logic [9:0] code;
        int         n;
        if (!reset) begin
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_out_code",  32'(out_code),  32'(0));
            chk("rst_rd",        32'(rd_state),  32'(0));
            chk("rst_sync_done", 32'(sync_done), 32'(0));
            chk("rst_k_err",     32'(k_err),     32'(0));
            chk("rst_disp_err",  32'(disp_err),  32'(0));
            chk("rst_in_ready",  32'(in_ready),  32'(1));
            mq.delete();
            m_sync  = 0;
            m_align = 0;
            m_rd    = 1'b0;
            e_valid = 1'b0;
            e_kerr  = 1'b0;
            e_derr  = 1'b0;
            e_code  = '0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            if (e_valid) chk("out_code", 32'(out_code), 32'(e_code));
            chk("k_err",     32'(k_err),     32'(e_kerr));
            chk("disp_err",  32'(disp_err),  32'(e_derr));
            chk("rd_state",  32'(rd_state),  32'(m_rd));
            chk("enc_rd",    32'(enc_rd),    32'(m_rd));
            chk("sync_done", 32'(sync_done), 32'(m_sync >= SYNC_LEN));
            chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
            if (k_err) kerr_cnt++;

            sym    = 9'h1BC;
            do_pop = 1'b0;
            sub    = 1'b0;
            if (m_sync >= SYNC_LEN && !(ALIGN_PERIOD != 0 && m_align == ALIGN_PERIOD - 1)
                && mq.size() > 0) begin
                do_pop = 1'b1;
                head   = mq[0];
                if (head[8] && !k_ok(head[7:0])) sub = 1'b1;
                else sym = head;
            end
            chk("enc_sym", 32'({enc_k, enc_data}), 32'(sym));
            if (sym_en) sent.push_back({enc_k, enc_data});

            do_push = in_valid && (mq.size() < DEPTH);
            if (sym_en) begin
                code    = ovr_en ? ovr_code : tb_enc(sym[7:0], sym[8], m_rd);
                n       = $countones(code);
                e_valid = 1'b1;
                e_code  = code;
                e_kerr  = sub;
                e_derr  = 1'b0;
                if (n == 5) m_rd = m_rd;
                else if (n == 6 && !m_rd) m_rd = 1'b1;
                else if (n == 4 && m_rd)  m_rd = 1'b0;
                else e_derr = 1'b1;
                if (m_sync < SYNC_LEN) m_sync++;
                m_align = (sym == 9'h1BC) ? 0 : m_align + 1;
                if (do_pop) void'(mq.pop_front());
            end else begin
                e_valid = 1'b0;
                e_kerr  = 1'b0;
                e_derr  = 1'b0;
            end
            if (do_push) mq.push_back({in_k, in_data});
        end
    end

    initial begin : stim_p
        int         s;
        int         v;
        logic       acc;
        logic [4:0] rdy;
        n_chk    = 0;
        n_err    = 0;
        kerr_cnt = 0;
        reset    = 1'b0;
        sym_en   = 1'b0;
        in_valid = 1'b0;
        in_k     = 1'b0;
        in_data  = 8'h00;
        ovr_en   = 1'b0;
        ovr_code = '0;
        repeat (3) tick();

        // Sync burst with a byte pushed during SYNC
        reset    = 1'b1;
        sym_en   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3A;
        s        = sent.size();
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        sym_en = 1'b0;
        for (int j = 0; j < 4; j++) chk_sent("t1_sync_sym", s + j, 9'h1BC);
        chk_sent("t1_first_data", s + 4, 9'h03A);
        chk("t1_sync_done", 32'(sync_done), 32'(1));

        // Disparity tracking with forced code words
        chk("t2_rd_start", 32'(rd_state), 32'(0));
        sym_en = 1'b1;
        ovr_en = 1'b1;
        ovr_code = 10'h03F; tick();
        chk("t2_rd_6", 32'(rd_state), 32'(1)); chk("t2_de_6", 32'(disp_err), 32'(0));
        ovr_code = 10'h00F; tick();
        chk("t2_rd_4", 32'(rd_state), 32'(0)); chk("t2_de_4", 32'(disp_err), 32'(0));
        ovr_code = 10'h01F; tick();
        chk("t2_rd_5", 32'(rd_state), 32'(0)); chk("t2_de_5", 32'(disp_err), 32'(0));
        ovr_code = 10'h03F; tick();
        chk("t2_rd_6b", 32'(rd_state), 32'(1)); chk("t2_de_6b", 32'(disp_err), 32'(0));
        ovr_code = 10'h03F; tick();
        chk("t2_rd_hold", 32'(rd_state), 32'(1)); chk("t2_de_bad", 32'(disp_err), 32'(1));
        sym_en = 1'b0;
        ovr_en = 1'b0;
        tick();
        chk("t2_de_pulse", 32'(disp_err), 32'(0));

        // Flow control with sym_en held low
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            rdy[i]   = in_ready;
            tick();
        end
        chk("t3_ready_seq", 32'(rdy), 32'(5'b01111));
        chk("t3_full", 32'(in_ready), 32'(0));
        s      = sent.size();
        sym_en = 1'b1;
        tick();
        sym_en = 1'b0;
        chk("t3_ready_back", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        sym_en   = 1'b1;
        repeat (4) tick();
        sym_en = 1'b0;
        for (int j = 0; j < 5; j++) chk_sent("t3_order", s + j, 9'(8'h11 * (j + 1)));

        // Periodic alignment on a continuous stream
        sym_en = 1'b1;
        tick();
        s = sent.size();
        v = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + v);
            acc      = in_ready;
            tick();
            if (acc) v++;
        end
        in_valid = 1'b0;
        chk("t4_accepted", 32'(v), 32'(24));
        for (int j = 0; j < 24; j++) begin
            if (j % 8 == 0) chk_sent("t4_comma", s + j, 9'h1BC);
            else            chk_sent("t4_data", s + j, 9'(8'h40 + (j - j / 8 - 1)));
        end
        repeat (12) tick();
        s = sent.size();
        repeat (10) tick();
        sym_en = 1'b0;
        for (int j = 0; j < 10; j++) chk_sent("t4_idle", s + j, 9'h1BC);

        // Invalid K substitution, valid K27.7 passthrough
        kerr_cnt = 0;
        in_valid = 1'b1;
        in_k     = 1'b1;
        in_data  = 8'h00;
        tick();
        in_data = 8'hFB;
        tick();
        in_valid = 1'b0;
        in_k     = 1'b0;
        s        = sent.size();
        sym_en   = 1'b1;
        repeat (2) tick();
        sym_en = 1'b0;
        repeat (2) tick();
        chk_sent("t5_subst", s, 9'h1BC);
        chk_sent("t5_k27_7", s + 1, 9'h1FB);
        chk("t5_kerr_pulses", 32'(kerr_cnt), 32'(1));

        // Reset in the middle of a stream
        if (!rd_state) begin
            sym_en = 1'b1;
            tick();
            sym_en = 1'b0;
        end
        chk("t6_rd_pre", 32'(rd_state), 32'(1));
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h61 + i);
            tick();
        end
        in_valid = 1'b0;
        sym_en   = 1'b1;
        tick();
        sym_en = 1'b0;
        chk("t6_ov_pre", 32'(out_valid), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("t6_ov_async", 32'(out_valid), 32'(0));
        chk("t6_rd_async", 32'(rd_state), 32'(0));
        chk("t6_rdy_async", 32'(in_ready), 32'(1));
        repeat (2) tick();
        reset  = 1'b1;
        sym_en = 1'b1;
        s      = sent.size();
        repeat (10) tick();
        sym_en = 1'b0;
        for (int j = 0; j < 10; j++) chk_sent("t6_no_old", s + j, 9'h1BC);
        chk("t6_sync_done", 32'(sync_done), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin : watchdog_p
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule

// File: doc/enc_tx_sched.md
Name: enc_tx_sched

Overview:
Transmit-side sequencer for the 8b/10b encoder datapath: it buffers incoming bytes, decides which symbol the combinational encoder sees each symbol slot, and owns the running disparity (RD) fed into the encoder.
- Sequencing: it inserts a K28.5 sync burst after reset, idle K28.5 commas on underflow, and periodic alignment commas.
- Output and checking: it registers the returned 10-bit code for the serializer and checks every code for disparity legality.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, >=2)
SYNC_LEN, 16, K28.5 symbols sent after reset before data is accepted out of the FIFO (>=1)
ALIGN_PERIOD, 256, max symbols between commas; 0 disables periodic insertion

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
sym_en  in  1  symbol-slot strobe from serializer; one symbol is issued per cycle with sym_en=1
in_valid  in  1  upstream byte valid
in_ready  out  1  FIFO not full
in_data  in  8  byte, bit 7 = H ... bit 0 = A
in_k  in  1  byte is a control character
enc_data  out  8  byte presented to encoder (combinational from selected symbol)
enc_k  out  1  K flag presented to encoder
enc_rd  out  1  current RD to encoder, 0 = RD-, 1 = RD+
enc_code  in  10  encoder result for enc_data/enc_k/enc_rd, same cycle
out_valid  out  1  one-cycle pulse: out_code updated
out_code  out  10  registered code word
rd_state  out  1  current RD register (equal to enc_rd)
sync_done  out  1  high once the SYNC burst completes
k_err  out  1  one-cycle pulse: invalid K byte replaced
disp_err  out  1  one-cycle pulse: illegal enc_code

Behaviour:
- Reset (reset=0, async) values:
  - Outputs: out_code=0, out_valid=0, rd=0 (RD-), sync_done=0, k_err=0, disp_err=0.
  - Internal: FIFO empty, state=SYNC, sync_cnt=0, align_cnt=0.
- Handshake and FIFO:
  - Push when in_valid & in_ready; in_ready = !full, registered-free.
  - Pop only on an issuing slot (sym_en=1, state DATA, FIFO non-empty, no forced comma).
  - Push and pop in the same cycle are both legal; count is unchanged.
  - When full, in_ready=0 and no push; a same-cycle pop does not raise in_ready until the next cycle.
- Symbol selection, evaluated when sym_en=1:
  - SYNC: always K28.5 (enc_data=8'hBC, enc_k=1); FIFO is not popped but still accepts pushes. sync_cnt increments; on the SYNC_LEN-th symbol, state goes to DATA and sync_done rises on that edge.
  - DATA, priority order:
    - (a) ALIGN_PERIOD!=0 and align_cnt==ALIGN_PERIOD-1: forced K28.5, no pop.
    - (b) FIFO non-empty: head entry, pop.
    - (c) otherwise: idle K28.5.
  - align_cnt resets to 0 on any emitted K28.5; otherwise it increments per emitted symbol.
  - When sym_en=0, enc_* still reflect the would-be symbol, but no state changes.
- K validation:
  - A popped entry with k=1 whose byte is not in {1C,3C,5C,7C,9C,BC,DC,FC,F7,FB,FD,FE} is sent as K28.5 instead, and k_err pulses on the issuing edge.
  - The substituted K28.5 counts as a comma for align_cnt.
- Output and latency:
  - On an issuing edge: out_code <= enc_code and out_valid=1 for one cycle.
  - Latency is one clk from the sym_en cycle to out_code.
- RD update, on an issuing edge, with n = number of ones in enc_code:
  - n=5: rd unchanged.
  - n=6 with rd=0: rd becomes 1.
  - n=4 with rd=1: rd becomes 0.
  - Any other n, or n=6 with rd=1, or n=4 with rd=0: disp_err pulses and rd is held. out_code still captures the code.
- Reset mid-stream:
  - Asserting reset discards FIFO contents and restarts SYNC.
  - No partial symbol is emitted; out_valid deasserts immediately.
- Simultaneous events: forced align comma has priority over a waiting FIFO entry. The entry stays at the head and is sent in the next slot.

Decomposition:
- Package enc8b10b_pkg contains:
  - constant K28_5 = 8'hBC;
  - RD encoding constants RD_NEG=0, RD_POS=1;
  - state enum {SYNC, DATA};
  - function is_valid_k(byte);
  - function ones10(code) returning a 4-bit count.
- Sub-module enc_sym_fifo holds 9-bit entries {k, data}, DEPTH entries, with push/pop/full/empty/head outputs and an asynchronous active-low reset. The scheduler instantiates it once.

Test Plan:
1. Sync burst: release reset with sym_en=1 every cycle and SYNC_LEN=4 → 4 out_valid pulses, each with enc_data=BC/enc_k=1, then sync_done=1. A byte pushed during SYNC appears as the 5th symbol.
2. Disparity tracking: the encoder model returns 6-ones, 4-ones, 5-ones codes starting from rd=0 → rd sequence 1, 0, 0 with disp_err=0. A following 6-ones then 6-ones sequence → second code pulses disp_err and rd stays 1.
3. Flow control: DEPTH=4, sym_en held 0, push 5 bytes → in_ready falls after 4 accepted. One sym_en pulse pops D0 and in_ready returns the next cycle. Bytes exit in order D0..D4.
4. Underflow and alignment: ALIGN_PERIOD=8 with a continuous data stream → a K28.5 every 8th symbol, and data order is preserved. With an empty FIFO, idle BC symbols are sent and each resets align_cnt.
5. Invalid K: push in_k=1, in_data=8'h00 → enc_data=BC/enc_k=1 is issued and k_err pulses once. A valid K27.7 (FB) passes unchanged.
6. Reset mid-stream: assert reset with 3 entries queued and rd=1 → out_valid=0, rd=0 and in_ready=1 immediately. After release, the SYNC burst restarts and the old bytes are never emitted.
